buzzer_pattern_driver: RTL
==========================

Name: buzzer_pattern_driver

Overview:
- Consumer end of the 2-bit per-side buzz-level interface produced by the obstacle detector.
- Converts each side's level (0 off, 1 slow beep, 2 fast beep, 3 continuous) into a gated square-wave tone on a buzzer pin.
- Sits between the detector outputs and the uo_out pads inside the top-level wrapper.
- Two identical channels share one millisecond tick and one tone generator.

Parameters:
TICK_DIV, 50000, clk cycles per pattern tick (1 ms at 50 MHz); must be >= 2
TONE_HALF, 12500, clk cycles per tone half-period (2 kHz at 50 MHz); must be >= 1
SLOW_ON, 200, ticks on for level 1
SLOW_OFF, 600, ticks off for level 1
FAST_ON, 50, ticks on for level 2
FAST_OFF, 100, ticks off for level 2
CNT_W, 10, width of the phase counter; every ON/OFF value must be >= 1 and < 2^CNT_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
left_level  in  2  left buzz level from the detector
right_level  in  2  right buzz level from the detector
left_buzz_out  out  1  left buzzer drive: tone AND left gate
right_buzz_out  out  1  right buzzer drive: tone AND right gate
left_gate  out  1  left pattern envelope, without tone
right_gate  out  1  right pattern envelope, without tone

Behaviour:
- Reset (async assert, sync release): all outputs 0, tick counter 0, tone 0, both channels IDLE, phase counters 0.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick_p is high for one cycle when counter == TICK_DIV-1.
- Tone: counter runs 0..TONE_HALF-1. The tone flop toggles on wrap. Tone is free-running and not tied to any channel.
- Channel FSM states: IDLE, ON, OFF, CONT. lvl_q holds the latched level (1 or 2).
- IDLE:
  - level 1/2 -> ON; lvl_q=level; cnt=ON ticks for that level.
  - level 3 -> CONT.
- ON:
  - On tick_p, cnt decrements.
  - tick_p with cnt==1 -> OFF; cnt=OFF ticks for lvl_q.
- OFF:
  - On tick_p, cnt decrements.
  - tick_p with cnt==1 -> re-sample level: 0 -> IDLE; 3 -> CONT; 1/2 -> ON, re-latch lvl_q, reload cnt.
- CONT:
  - level 1/2 -> ON with that level, fresh ON count.
  - level 0 -> IDLE.
- Overrides from any state, checked before other transitions:
  - level 0 -> IDLE next cycle (immediate silence).
  - level 3 -> CONT next cycle.
- Change between levels 1 and 2 during ON/OFF: no effect until the current period ends. The pattern always finishes a full on+off period.
- gate = (state==ON || state==CONT), registered. Latency from level change to gate change is 1 clk for override and IDLE-exit cases.
- buzz_out = gate & tone, combinational from flops, so it is glitch-free.
- The first ON phase after leaving IDLE may be up to 1 tick shorter, because the tick is not restarted. This is accepted.
- Left and right channels are fully independent, and simultaneous events on both are handled in parallel.

Optional Feature:
- Macro: BUZZ_SYNC_EN.
- Defined: each level input passes through a 2-flop synchronizer (reset 0) before the FSM. This lets levels come directly from pads. Input-to-gate latency becomes 3 clk.
- Undefined: levels feed the FSM directly, with 1 clk latency. No synchronizer flops are present.

Decomposition:
- Package buzz_pkg:
  - level constants LVL_OFF=2'd0, LVL_SLOW=2'd1, LVL_FAST=2'd2, LVL_CONT=2'd3.
  - channel state enum (IDLE, ON, OFF, CONT).
- Sub-module buzz_channel:
  - one FSM, phase counter and optional synchronizer per side.
  - instantiated twice.
- The top holds the shared tick and tone generators and the output ANDs.

Test Plan:
All scenarios use TICK_DIV=4, TONE_HALF=2, SLOW_ON=3, SLOW_OFF=5, FAST_ON=1, FAST_OFF=2, and BUZZ_SYNC_EN undefined unless stated.
1. Reset held, levels=3 -> all outputs 0. After release, left_gate=1 one clk after the first edge; left_buzz_out toggles every 2 clk in phase with tone.
2. left_level=1 held -> left_gate pattern repeats 3 ticks high, 5 ticks low (12 clk high, 20 clk low in steady state). right_gate stays 0.
3. left_level=2, then 1 mid-ON -> the current fast period completes (1 tick on, 2 ticks off); the next period is slow (3 on / 5 off).
4. left_level=1 in ON, then 0 -> left_gate=0 on the next clk, state IDLE. Level 1 -> 3 during OFF -> gate=1 on the next clk.
5. left=2 and right=3 simultaneously, then assert rst_n low mid-pattern -> both gates drop asynchronously. After release, both restart from IDLE and are independent.
6. With BUZZ_SYNC_EN defined, level 0 -> 3 -> gate rises exactly 3 clk after the input edge. A 1-clk glitch to 3 still produces 1 clk of CONT; this is the intended behaviour.

Source files
------------

// File: rtl/buzz_pkg.sv
// rtl/buzz_pkg.sv - shared buzz level codes and channel state type
package buzz_pkg;

  localparam logic [1:0] LVL_OFF  = 2'd0;
  localparam logic [1:0] LVL_SLOW = 2'd1;
  localparam logic [1:0] LVL_FAST = 2'd2;
  localparam logic [1:0] LVL_CONT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_CONT = 2'd3
  } ch_state_e;

endpackage

// File: rtl/buzz_channel.sv
// rtl/buzz_channel.sv - one buzzer pattern channel: optional level synchronizer (BUZZ_SYNC_EN), FSM, phase counter
module buzz_channel
  import buzz_pkg::*;
#(
  parameter int SLOW_ON  = 200,
  parameter int SLOW_OFF = 600,
  parameter int FAST_ON  = 50,
  parameter int FAST_OFF = 100,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [1:0] level_i,
  output logic       gate_o
);

  localparam logic [CNT_W-1:0] SLOW_ON_C  = CNT_W'(SLOW_ON);
  localparam logic [CNT_W-1:0] SLOW_OFF_C = CNT_W'(SLOW_OFF);
  localparam logic [CNT_W-1:0] FAST_ON_C  = CNT_W'(FAST_ON);
  localparam logic [CNT_W-1:0] FAST_OFF_C = CNT_W'(FAST_OFF);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       level_s;
  ch_state_e        state_q, state_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q;

`ifdef BUZZ_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  // Two-flop synchronizer so levels may come straight from pads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= LVL_OFF;
      sync2_q <= LVL_OFF;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_s = sync2_q;
`else
  assign level_s = level_i;
`endif

  function automatic logic [CNT_W-1:0] on_ticks(input logic [1:0] l);
    return (l == LVL_SLOW) ? SLOW_ON_C : FAST_ON_C;
  endfunction

  function automatic logic [CNT_W-1:0] off_ticks(input logic [1:0] l);
    return (l == LVL_SLOW) ? SLOW_OFF_C : FAST_OFF_C;
  endfunction

  // Next-state: level 0/3 override everything, otherwise the pattern runs a full on+off period
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    if (level_s == LVL_OFF) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (level_s == LVL_CONT) begin
      state_d = ST_CONT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_CONT: begin
          state_d = ST_ON;
          lvl_d   = level_s;
          cnt_d   = on_ticks(level_s);
        end
        ST_ON: begin
          if (tick_i) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_OFF;
              cnt_d   = off_ticks(lvl_q);
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_OFF: begin
          if (tick_i) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_ON;
              lvl_d   = level_s;
              cnt_d   = on_ticks(level_s);
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, phase counter and registered envelope
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lvl_q   <= LVL_OFF;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      gate_q  <= (state_d == ST_ON) || (state_d == ST_CONT);
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/buzzer_pattern_driver.sv
// rtl/buzzer_pattern_driver.sv - two-channel buzzer pattern driver with shared tick and tone (BUZZ_SYNC_EN adds input synchronizers)
module buzzer_pattern_driver
  import buzz_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int TONE_HALF = 12500,
  parameter int SLOW_ON   = 200,
  parameter int SLOW_OFF  = 600,
  parameter int FAST_ON   = 50,
  parameter int FAST_OFF  = 100,
  parameter int CNT_W     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] left_level,
  input  logic [1:0] right_level,
  output logic       left_buzz_out,
  output logic       right_buzz_out,
  output logic       left_gate,
  output logic       right_gate
);

  localparam int TICK_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TONE_W-1:0] tone_cnt_q;
  logic              tone_q;
  logic              tick_p;

  assign tick_p = (tick_cnt_q == TICK_LAST);

  // Pattern tick divider, wraps every TICK_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick_p) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // Free-running tone square wave, toggles each half-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TONE_LAST) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TONE_W'(1);
    end
  end

  buzz_channel #(
    .SLOW_ON (SLOW_ON),
    .SLOW_OFF(SLOW_OFF),
    .FAST_ON (FAST_ON),
    .FAST_OFF(FAST_OFF),
    .CNT_W   (CNT_W)
  ) u_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_p),
    .level_i(left_level),
    .gate_o (left_gate)
  );

  buzz_channel #(
    .SLOW_ON (SLOW_ON),
    .SLOW_OFF(SLOW_OFF),
    .FAST_ON (FAST_ON),
    .FAST_OFF(FAST_OFF),
    .CNT_W   (CNT_W)
  ) u_right (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_p),
    .level_i(right_level),
    .gate_o (right_gate)
  );

  // Both operands are flop outputs, so the gated tone cannot glitch
  assign left_buzz_out  = left_gate  & tone_q;
  assign right_buzz_out = right_gate & tone_q;

endmodule
